// File: rtl/mac_ctrl_if.sv
// Operand-fetch / MAC / result-write bus between mac_ctrl and its environment.
interface mac_ctrl_if;
  logic       start;
  logic       abort;
  logic [5:0] rd_addr;
  logic [7:0] rd_a;
  logic [7:0] rd_b;
  logic       mac_en;
  logic [7:0] mac_a;
  logic [7:0] mac_b;
  logic [2:0] mac_addr;
  logic [7:0] mac_out;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;

  modport master (
    input  start, abort, rd_a, rd_b, mac_out,
    output rd_addr, mac_en, mac_a, mac_b, mac_addr, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    output start, abort, rd_a, rd_b, mac_out,
    input  rd_addr, mac_en, mac_a, mac_b, mac_addr, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/mac_ctrl.sv
// Row-sequencing controller: streams 8 operand pairs per row into an external MAC,
// waits for the result to settle, then writes it back; ROWS rows per job.
module mac_ctrl #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned EN_CYC  = 10,
  parameter int unsigned CAP_DLY = 2
) (
  input  logic       clk,
  input  logic       rst,
  mac_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(EN_CYC + CAP_DLY + 1);
  localparam int unsigned ROW_W = 3;
  localparam int unsigned DAT_W = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREF  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state_q,   state_d;
  logic [ROW_W-1:0] row_q,     row_d;
  logic [ROW_W-1:0] k_q,       k_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             mac_en_q,  mac_en_d;
  logic [DAT_W-1:0] mac_a_q,   mac_a_d;
  logic [DAT_W-1:0] mac_b_q,   mac_b_d;
  logic             wr_en_q,   wr_en_d;
  logic [ROW_W-1:0] wr_addr_q, wr_addr_d;
  logic [DAT_W-1:0] wr_data_q, wr_data_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      mac_en_q  <= 1'b0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      mac_en_q  <= mac_en_d;
      mac_a_q   <= mac_a_d;
      mac_b_q   <= mac_b_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Operands are loaded on the edge entering each RUN cycle, so the address runs one element ahead.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    mac_en_d  = mac_en_q;
    mac_a_d   = mac_a_q;
    mac_b_d   = mac_b_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_PREF;
          row_d   = '0;
          k_d     = '0;
        end
      end
      S_PREF: begin
        state_d  = S_RUN;
        k_d      = ROW_W'(1);
        cnt_d    = '0;
        mac_en_d = 1'b1;
        mac_a_d  = bus.rd_a;
        mac_b_d  = bus.rd_b;
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(EN_CYC - 1)) begin
          state_d  = S_DRAIN;
          cnt_d    = '0;
          mac_en_d = 1'b0;
          mac_a_d  = '0;
          mac_b_d  = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          mac_a_d = (cnt_q < CNT_W'(7)) ? bus.rd_a : '0;
          mac_b_d = (cnt_q < CNT_W'(7)) ? bus.rd_b : '0;
          k_d     = (k_q == ROW_W'(7)) ? k_q : k_q + ROW_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(CAP_DLY - 1)) begin
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = row_q;
          wr_data_d = bus.mac_out;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (row_q == ROW_W'(ROWS - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_PREF;
          row_d   = row_q + ROW_W'(1);
          k_d     = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        row_d   = '0;
        k_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a pending write strobe and a start in IDLE.
    if (bus.abort) begin
      state_d  = S_IDLE;
      row_d    = '0;
      k_d      = '0;
      cnt_d    = '0;
      mac_en_d = 1'b0;
      mac_a_d  = '0;
      mac_b_d  = '0;
      wr_en_d  = 1'b0;
      done_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.rd_addr  = {row_q, k_q};
  assign bus.mac_en   = mac_en_q;
  assign bus.mac_a    = mac_a_q;
  assign bus.mac_b    = mac_b_q;
  assign bus.mac_addr = row_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_mac_ctrl.sv
// Directed bench for mac_ctrl: operand memory, a small pipelined MAC and a bus monitor.
module tb_mac_ctrl;

  localparam int JOB_CYC = 113;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mac_ctrl_if bus ();
  mac_ctrl_if bus1 ();

  mac_ctrl #(.ROWS(8), .EN_CYC(10), .CAP_DLY(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mac_ctrl #(.ROWS(1), .EN_CYC(10), .CAP_DLY(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int vectors = 0;
  int miscompares = 0;

  // Operand memory a[r,k] = k+1+a_off, b = b_val; async read of the registered address.
  logic [7:0] a_off = 8'd0;
  logic [7:0] b_val = 8'd1;
  logic       mac_stub = 1'b0;
  assign bus.rd_a  = 8'(bus.rd_addr[2:0]) + 8'd1 + a_off;
  assign bus.rd_b  = b_val;
  assign bus1.rd_a = 8'(bus1.rd_addr[2:0]) + 8'd1;
  assign bus1.rd_b = 8'd1;
  assign bus1.mac_out = 8'h5C;

  // MAC model: accumulator cleared while mac_en is low, one-stage output register.
  logic [7:0] acc = 8'd0;
  logic [7:0] out_q = 8'd0;
  always @(posedge clk) begin
    acc   <= bus.mac_en ? acc + 8'(bus.mac_a * bus.mac_b) : 8'd0;
    out_q <= acc;
  end
  assign bus.mac_out = mac_stub ? 8'hA5 : out_q;

  // Bus monitor sampling on the falling edge.
  logic       stats_clr = 1'b0;
  int cyc = 0, wr_n = 0, done_n = 0, done_cyc = 0, runs_n = 0, run_len = 0;
  int run_min = 999, run_max = 0, gap = 0, gap_min = 999, seq_n = 0;
  logic [7:0] mac_seq [16];
  logic [2:0] wr_addr_log [16];
  logic [7:0] wr_data_log [16];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (stats_clr) begin
      wr_n <= 0; done_n <= 0; runs_n <= 0; run_len <= 0; run_min <= 999;
      run_max <= 0; gap <= 0; gap_min <= 999; seq_n <= 0;
    end else begin
      if (bus.wr_en) begin
        if (wr_n < 16) begin
          wr_addr_log[wr_n] <= bus.wr_addr;
          wr_data_log[wr_n] <= bus.wr_data;
        end
        wr_n <= wr_n + 1;
      end
      if (bus.done) begin
        done_n   <= done_n + 1;
        done_cyc <= cyc + 1;
      end
      if (bus.mac_en) begin
        run_len <= run_len + 1;
        if (run_len == 0 && runs_n > 0 && gap < gap_min) gap_min <= gap;
        if (runs_n == 0 && seq_n < 16) begin
          mac_seq[seq_n] <= bus.mac_a;
          seq_n <= seq_n + 1;
        end
      end else if (run_len > 0) begin
        runs_n <= runs_n + 1;
        if (run_len < run_min) run_min <= run_len;
        if (run_len > run_max) run_max <= run_len;
        run_len <= 0;
        gap <= 1;
      end else begin
        gap <= gap + 1;
      end
    end
  end

  task automatic clear_stats();
    stats_clr = 1'b1;
    @(negedge clk); #1;
    stats_clr = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_job(output int t0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && done_n == 0; i++) step(1);
    step(4);
  endtask

  task automatic test_reset();
    logic [39:0] outs;
    rst = 1'b0;
    #12;
    outs = {bus.busy, bus.done, bus.mac_en, bus.wr_en, bus.rd_addr, bus.mac_a, bus.mac_b,
            bus.mac_addr, bus.wr_addr, bus.wr_data};
    vectors++; if (outs !== 40'd0) begin miscompares++; $display("FAIL reset_outs: got %h expected 0", outs); end
    vectors++; if ({bus1.busy, bus1.mac_en, bus1.rd_addr} !== 8'd0) begin miscompares++; $display("FAIL reset_outs1: got %h expected 0", {bus1.busy, bus1.mac_en, bus1.rd_addr}); end
    @(posedge clk); #1;
    rst = 1'b1;
    step(3);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_full_job();
    int t0;
    clear_stats();
    start_job(t0);
    vectors++; if (bus.busy !== 1'b1 || bus.rd_addr !== 6'd0) begin miscompares++; $display("FAIL pref: busy %b rd_addr %0d expected 1/0", bus.busy, bus.rd_addr); end
    wait_done();
    vectors++; if (done_cyc - t0 !== JOB_CYC) begin miscompares++; $display("FAIL job_latency: got %0d expected %0d", done_cyc - t0, JOB_CYC); end
    vectors++; if (done_n !== 1) begin miscompares++; $display("FAIL done_count: got %0d expected 1", done_n); end
    vectors++; if (wr_n !== 8) begin miscompares++; $display("FAIL wr_count: got %0d expected 8", wr_n); end
    for (int r = 0; r < 8; r++) begin
      vectors++; if (wr_addr_log[r] !== 3'(r)) begin miscompares++; $display("FAIL wr_addr[%0d]: got %0d expected %0d", r, wr_addr_log[r], r); end
      vectors++; if (wr_data_log[r] !== 8'd36) begin miscompares++; $display("FAIL wr_data[%0d]: got %0d expected 36", r, wr_data_log[r]); end
    end
    vectors++; if (runs_n !== 8 || run_min !== 10 || run_max !== 10) begin miscompares++; $display("FAIL mac_en_runs: got n=%0d min=%0d max=%0d expected 8/10/10", runs_n, run_min, run_max); end
    for (int i = 0; i < 10; i++) begin
      vectors++; if (mac_seq[i] !== ((i < 8) ? 8'(i + 1) : 8'd0)) begin miscompares++; $display("FAIL mac_a_seq[%0d]: got %0d expected %0d", i, mac_seq[i], (i < 8) ? i + 1 : 0); end
    end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL busy_after_job: got %b expected 0", bus.busy); end
  endtask

  task automatic test_rows1();
    int done_at = 0, wr_cnt = 0;
    logic [2:0] wa = 3'd7;
    logic [7:0] wd = 8'd0;
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (bus1.done && done_at == 0) done_at = i;
      if (bus1.wr_en) begin wr_cnt++; wa = bus1.wr_addr; wd = bus1.wr_data; end
      step(1);
    end
    vectors++; if (done_at !== 15) begin miscompares++; $display("FAIL rows1_done: got %0d expected 15", done_at); end
    vectors++; if (wr_cnt !== 1) begin miscompares++; $display("FAIL rows1_wr_count: got %0d expected 1", wr_cnt); end
    vectors++; if (wa !== 3'd0 || wd !== 8'h5C) begin miscompares++; $display("FAIL rows1_write: got addr %0d data %h expected 0/5c", wa, wd); end
    vectors++; if (bus1.busy !== 1'b0) begin miscompares++; $display("FAIL rows1_busy: got %b expected 0", bus1.busy); end
  endtask

  task automatic test_data_pattern();
    int t0;
    a_off = 8'd2; b_val = 8'd3;
    clear_stats();
    start_job(t0);
    wait_done();
    vectors++; if (wr_n !== 8 || done_n !== 1) begin miscompares++; $display("FAIL pattern_counts: got wr %0d done %0d expected 8/1", wr_n, done_n); end
    for (int r = 0; r < 8; r++) begin
      vectors++; if (wr_data_log[r] !== 8'd156) begin miscompares++; $display("FAIL pattern_data[%0d]: got %0d expected 156", r, wr_data_log[r]); end
    end
    a_off = 8'd0; b_val = 8'd1;
  endtask

  task automatic test_stub();
    int t0;
    mac_stub = 1'b1;
    clear_stats();
    start_job(t0);
    wait_done();
    vectors++; if (wr_n !== 8) begin miscompares++; $display("FAIL stub_wr_count: got %0d expected 8", wr_n); end
    for (int r = 0; r < 8; r++) begin
      vectors++; if (wr_data_log[r] !== 8'hA5) begin miscompares++; $display("FAIL stub_data[%0d]: got %h expected a5", r, wr_data_log[r]); end
    end
    vectors++; if (gap_min !== 4) begin miscompares++; $display("FAIL row_gap: got %0d expected 4", gap_min); end
    mac_stub = 1'b0;
  endtask

  task automatic test_abort_run();
    int t0;
    clear_stats();
    start_job(t0);
    for (int i = 0; i < 200 && !(wr_n == 3 && bus.mac_en); i++) step(1);
    step(3);
    vectors++; if (bus.mac_addr !== 3'd3 || bus.rd_addr[5:3] !== 3'd3 || bus.mac_en !== 1'b1) begin miscompares++; $display("FAIL row3_run: got mac_addr %0d rd_row %0d mac_en %b expected 3/3/1", bus.mac_addr, bus.rd_addr[5:3], bus.mac_en); end
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    vectors++; if (bus.mac_en !== 1'b0 || bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL abort_run: got mac_en %b busy %b wr_en %b expected 0/0/0", bus.mac_en, bus.busy, bus.wr_en); end
    vectors++; if (bus.rd_addr !== 6'd0 || bus.mac_addr !== 3'd0) begin miscompares++; $display("FAIL abort_clear: got rd_addr %0d mac_addr %0d expected 0/0", bus.rd_addr, bus.mac_addr); end
    step(150);
    vectors++; if (wr_n !== 3 || done_n !== 0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_after: got wr %0d done %0d busy %b expected 3/0/0", wr_n, done_n, bus.busy); end
  endtask

  task automatic test_abort_write();
    int t0;
    clear_stats();
    start_job(t0);
    step(12);
    vectors++; if (bus.mac_en !== 1'b0 || bus.busy !== 1'b1 || bus.wr_en !== 1'b0) begin miscompares++; $display("FAIL drain_state: got mac_en %b busy %b wr_en %b expected 0/1/0", bus.mac_en, bus.busy, bus.wr_en); end
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    vectors++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_write: got wr_en %b busy %b expected 0/0", bus.wr_en, bus.busy); end
    step(20);
    vectors++; if (wr_n !== 0 || done_n !== 0) begin miscompares++; $display("FAIL abort_write_after: got wr %0d done %0d expected 0/0", wr_n, done_n); end
    bus.start = 1'b1; bus.abort = 1'b1;
    step(1);
    bus.start = 1'b0; bus.abort = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_start_idle: got busy %b expected 0", bus.busy); end
    step(3);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_start_stay: got busy %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [39:0] outs;
    clear_stats();
    start_job(t0);
    for (int i = 0; i < 200 && !(wr_n == 5 && bus.mac_en); i++) step(1);
    for (int i = 0; i < 20 && bus.mac_en; i++) step(1);
    #2 rst = 1'b0;
    #1;
    outs = {bus.busy, bus.done, bus.mac_en, bus.wr_en, bus.rd_addr, bus.mac_a, bus.mac_b,
            bus.mac_addr, bus.wr_addr, bus.wr_data};
    vectors++; if (outs !== 40'd0) begin miscompares++; $display("FAIL reset_mid_outs: got %h expected 0", outs); end
    step(3);
    rst = 1'b1;
    step(150);
    vectors++; if (wr_n !== 5 || done_n !== 0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_mid_after: got wr %0d done %0d busy %b expected 5/0/0", wr_n, done_n, bus.busy); end
    rst = 1'b0;
    clear_stats();
    rst = 1'b1;
    start_job(t0);
    wait_done();
    vectors++; if (done_cyc - t0 !== JOB_CYC || wr_n !== 8 || done_n !== 1) begin miscompares++; $display("FAIL restart_job: got latency %0d wr %0d done %0d expected %0d/8/1", done_cyc - t0, wr_n, done_n, JOB_CYC); end
  endtask

  task automatic test_start_held();
    int i = 1;
    clear_stats();
    bus.start = 1'b1;
    step(1);
    while (!bus.done && i < 200) begin step(1); i++; end
    vectors++; if (i !== JOB_CYC) begin miscompares++; $display("FAIL held_done_cycle: got %0d expected %0d", i, JOB_CYC); end
    vectors++; if (wr_n !== 8) begin miscompares++; $display("FAIL held_wr_count: got %0d expected 8", wr_n); end
    step(1);
    vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL held_idle: got busy %b done %b expected 0/0", bus.busy, bus.done); end
    step(1);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL held_restart: got busy %b expected 1", bus.busy); end
    bus.start = 1'b0;
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL held_abort: got busy %b expected 0", bus.busy); end
  endtask

  initial begin
    bus.start = 1'b0;  bus.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    test_reset();
    test_full_job();
    test_rows1();
    test_data_pattern();
    test_stub();
    test_abort_run();
    test_abort_write();
    test_reset_mid();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mac_ctrl.md
MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 Parameter ROWS, default 8: rows per job, 1..8.
REQ-002 Parameter EN_CYC, default 10: cycles mac_en is held high per row, >=9 (8 operand pairs plus pipeline flush).
REQ-003 Parameter CAP_DLY, default 2: cycles from mac_en fall to result capture, >=1.
REQ-004 clk  in  1  single clock; all flops on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle job request; honoured only in IDLE.
REQ-007 abort  in  1  synchronous job cancel.
REQ-008 rd_addr  out  6  operand memory address {row[2:0], k[2:0]}.
REQ-009 rd_a, rd_b  in  8 each  operand data, valid one cycle after rd_addr.
REQ-010 mac_en  out  1  MAC enable; low clears the MAC accumulator.
REQ-011 mac_a, mac_b  out  8 each  MAC operands.
REQ-012 mac_addr  out  3  row tag to MAC.
REQ-013 mac_out  in  8  MAC result.
REQ-014 wr_en  out  1  one-cycle result write strobe.
REQ-015 wr_addr  out  3  result row index.
REQ-016 wr_data  out  8  captured mac_out.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse at job completion.

Function
REQ-019 FSM states: IDLE, PREF, RUN, DRAIN, WRITE, DONE; all outputs registered.
REQ-020 IDLE: start=1 -> PREF; row<=0, k<=0, rd_addr<={0,0}.
REQ-021 PREF lasts exactly 1 cycle (memory latency), issues rd_addr={row,1}, then -> RUN.
REQ-022 RUN: mac_en=1 for exactly EN_CYC consecutive cycles, tracked by a run counter 0..EN_CYC-1.
REQ-023 RUN cycles 0..7: mac_a/mac_b = rd_a/rd_b of element k=cycle index; rd_addr advances one element ahead, k saturates at 7 (no wrap into next row).
REQ-024 RUN cycles 8..EN_CYC-1: mac_a=mac_b=0.
REQ-025 mac_addr = row throughout RUN, DRAIN, WRITE.
REQ-026 After run counter = EN_CYC-1 -> DRAIN; mac_en=0 and mac_a=mac_b=0 from first DRAIN cycle.
REQ-027 DRAIN lasts CAP_DLY cycles; on its last cycle wr_data<=mac_out -> WRITE.
REQ-028 WRITE lasts 1 cycle: wr_en=1, wr_addr=row, wr_data held.
REQ-029 WRITE, row<ROWS-1: row<=row+1, k<=0, rd_addr<={row+1,0} -> PREF.
REQ-030 WRITE, row=ROWS-1: -> DONE; DONE pulses done=1 for 1 cycle -> IDLE.
REQ-031 mac_en is low for at least 1+CAP_DLY cycles between consecutive rows (DRAIN+WRITE+PREF), guaranteeing accumulator clear.
REQ-032 start outside IDLE is ignored; start in DONE cycle is ignored.
REQ-033 abort=1 in any non-IDLE state -> IDLE next cycle; mac_en=0, wr_en=0, no done pulse, row/k cleared.
REQ-034 abort and start in same IDLE cycle: abort wins, stay IDLE.
REQ-035 abort in WRITE suppresses that cycle's wr_en (abort has priority over write).
REQ-036 Per-row latency PREF-to-WRITE = 1+EN_CYC+CAP_DLY+1 cycles; job = ROWS*(EN_CYC+CAP_DLY+2)+1 cycles from start to done (defaults: 113).

Reset
REQ-037 rst=0 forces asynchronously: state IDLE; mac_en, wr_en, done, busy = 0; mac_a, mac_b, mac_addr, rd_addr, wr_addr, wr_data, row, k, run counter = 0.
REQ-038 Reset mid-job discards the job; no write or done after release; start required to restart.
REQ-039 First start is accepted on the first rising edge with rst=1.

Verification
REQ-040 Defaults, memory a[r,k]=k+1, b=1, start -> mac_en high exactly 10 cycles per row, mac_a sequence 1..8 then 0,0, wr_en 8 times with wr_addr 0..7, done once at cycle 113.
REQ-041 ROWS=1, start -> single wr_en, wr_addr=0, done 15 cycles after start.
REQ-042 abort asserted in RUN of row 3 -> mac_en low next cycle, no further wr_en, no done, busy=0.
REQ-043 rst=0 pulsed mid-DRAIN of row 5 -> all outputs 0 immediately; no wr_en after release; new start runs full 8-row job.
REQ-044 start held high continuously -> one job, then a new job starts on first IDLE cycle after done; start during busy has no effect.
REQ-045 Stub MAC returning mac_out=8'hA5 at capture -> wr_data=8'hA5 during wr_en; mac_en low gap between rows >=3 cycles.
